// File: rtl/joypad_responder_if.sv
// joypad_responder_if: NES core <-> controller responder joypad bundle (strobe, clocks, buttons, serial data).
// Latency: none, wires only.
// Backpressure: none; the NES core paces every read.
interface joypad_responder_if;
   logic       joy_strobe;
   logic [1:0] joy_clock;
   logic [7:0] buttons_p1;
   logic [7:0] buttons_p2;
   logic [1:0] autofire_en;
   logic [1:0] joy_data;
   logic [7:0] bit_count;

   // NES core / button-source side
   modport master (
      output joy_strobe,
      output joy_clock,
      output buttons_p1,
      output buttons_p2,
      output autofire_en,
      input  joy_data,
      input  bit_count
   );

   // Responder side
   modport slave (
      input  joy_strobe,
      input  joy_clock,
      input  buttons_p1,
      input  buttons_p2,
      input  autofire_en,
      output joy_data,
      output bit_count
   );
endinterface

// File: rtl/joypad_responder.sv
// joypad_responder: two-port 4021-style serial joypad responder with A/B autofire and d-pad filtering.
// Latency: buttons -> joy_data 2 cycles under strobe; joy_clock fall -> next bit 1 cycle after it is sampled.
// Backpressure: none; the NES core paces every read and the responder always follows.
module joypad_responder #(
   parameter int C_clk_hz      = 21428571,
   parameter int C_autofire_hz = 10,
   parameter int C_dpad_filter = 1
) (
   input logic               clock,
   input logic               R_reset,
   joypad_responder_if.slave joy
);

   // Half period of the autofire square wave in system clocks
   localparam int HALF  = (C_autofire_hz == 0) ? 1 : C_clk_hz / (2 * C_autofire_hz);
   localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

   logic [1:0][7:0] btn_r;
   logic [1:0]      af_en_r;
   logic            af_phase;
   logic [1:0]      clk_prev;
   logic [1:0]      fall;
   logic [1:0][7:0] masked;
   logic [1:0][7:0] shift;
   logic [1:0][3:0] cnt;

   // Apply opposing-direction filter and autofire gating to one player's vector
   function automatic logic [7:0] mask_buttons(input logic [7:0] b,
                                                input logic       af_en,
                                                input logic       phase);
      logic [7:0] m;
      m = b;
      if (C_dpad_filter != 0) begin
         if (m[4] && m[5]) m[5:4] = 2'b00;
         if (m[6] && m[7]) m[7:6] = 2'b00;
      end
      if (af_en) m[1:0] = m[1:0] & {2{phase}};
      return m;
   endfunction

   // Register the button sources and autofire enables once
   always_ff @(posedge clock) begin
      if (R_reset) begin
         btn_r   <= '0;
         af_en_r <= '0;
      end else begin
         btn_r[0] <= joy.buttons_p1;
         btn_r[1] <= joy.buttons_p2;
         af_en_r  <= joy.autofire_en;
      end
   end

   generate
      if (C_autofire_hz == 0) begin : g_no_af
         // Generator disabled: A/B always pass through
         assign af_phase = 1'b1;
      end else begin : g_af
         logic [DIV_W-1:0] div_cnt;
         logic             phase_q;

         // Divider counts one half period, then flips the autofire phase
         always_ff @(posedge clock) begin
            if (R_reset) begin
               div_cnt <= '0;
               phase_q <= 1'b0;
            end else if (div_cnt == DIV_W'(HALF - 1)) begin
               div_cnt <= '0;
               phase_q <= ~phase_q;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end

         assign af_phase = phase_q;
      end
   endgenerate

   // Falling-edge detect on each port's read clock and per-player masked vectors
   always_comb begin
      fall = clk_prev & ~joy.joy_clock;
      for (int p = 0; p < 2; p++) begin
         masked[p] = mask_buttons(btn_r[p], af_en_r[p], af_phase);
      end
   end

   // Previous read-clock level for edge detection
   always_ff @(posedge clock) begin
      if (R_reset) clk_prev <= '0;
      else         clk_prev <= joy.joy_clock;
   end

   // Per-port shift register: strobe reloads, falling edge shifts in 1s, otherwise hold
   always_ff @(posedge clock) begin
      if (R_reset) begin
         shift <= '0;
         cnt   <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (joy.joy_strobe) begin
               shift[i] <= masked[i];
               cnt[i]   <= 4'd0;
            end else if (fall[i]) begin
               shift[i] <= {1'b1, shift[i][7:1]};
               cnt[i]   <= (cnt[i] == 4'd8) ? 4'd8 : cnt[i] + 4'd1;
            end
         end
      end
   end

   assign joy.joy_data  = {shift[1][0], shift[0][0]};
   assign joy.bit_count = cnt;

endmodule
